// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between NUM_MASTERS requesters; one transaction in flight.
// Latency: request seen in IDLE -> s_req next cycle; m_ready the cycle after s_ready; next s_req 2 cycles after m_ready.
// Backpressure: winner holds m_req until m_ready; memory stalls by keeping s_ready low (s_* payload held stable).
//
// Ports: clk/rst (sync, active-high); m_req/m_we/m_addr/m_wdata/m_wstrb are flattened per-master requests
// (master i at [i*W +: W]); m_ready is a one-cycle completion pulse to the winner, with m_rdata/m_err
// valid alongside it; s_* is the registered memory-side request, completed by s_ready/s_rdata;
// grant_id is the current/last winner and busy is high whenever a transaction is in progress.
// Optional: define ARB_TIMEOUT_EN to add a BUSY watchdog (TIMEOUT_CYCLES) that completes the
// transaction with m_err=1 and m_rdata=0xDEADBEEF when the memory never answers.
module mem_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
`ifdef ARB_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 64,
`endif
    localparam int GID_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        m_req,
    input  logic [NUM_MASTERS-1:0]        m_we,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    input  logic [NUM_MASTERS*STRB_W-1:0] m_wstrb,
    output logic [NUM_MASTERS-1:0]        m_ready,
    output logic [DATA_W-1:0]             m_rdata,
    output logic                          m_err,
    output logic                          s_req,
    output logic                          s_we,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [STRB_W-1:0]             s_wstrb,
    input  logic                          s_ready,
    input  logic [DATA_W-1:0]             s_rdata,
    output logic [GID_W-1:0]              grant_id,
    output logic                          busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [GID_W-1:0]         ptr_q, ptr_d;
    logic [GID_W-1:0]         grant_id_q, grant_id_d;
    logic                     s_req_q, s_req_d;
    logic                     s_we_q, s_we_d;
    logic [ADDR_W-1:0]        s_addr_q, s_addr_d;
    logic [DATA_W-1:0]        s_wdata_q, s_wdata_d;
    logic [STRB_W-1:0]        s_wstrb_q, s_wstrb_d;
    logic [DATA_W-1:0]        m_rdata_q, m_rdata_d;
    logic [NUM_MASTERS-1:0]   m_ready_q, m_ready_d;

`ifdef ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(32'hDEADBEEF);
    logic [WD_W-1:0]          wdog_q, wdog_d;
    logic                     m_err_q, m_err_d;
`endif

    // Per-master views of the flattened request payloads.
    logic [ADDR_W-1:0] addr_arr  [NUM_MASTERS];
    logic [DATA_W-1:0] wdata_arr [NUM_MASTERS];
    logic [STRB_W-1:0] wstrb_arr [NUM_MASTERS];

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
        assign addr_arr[gi]  = m_addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = m_wdata[gi*DATA_W +: DATA_W];
        assign wstrb_arr[gi] = m_wstrb[gi*STRB_W +: STRB_W];
    end

    // Round-robin pick: first asserted request scanning upward from ptr, wrapping.
    logic             win_vld;
    logic [GID_W-1:0] win_idx;

    always_comb begin
        int cand;
        win_vld = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_MASTERS) begin
                cand = cand - NUM_MASTERS;
            end
            if (!win_vld && m_req[GID_W'(cand)]) begin
                win_vld = 1'b1;
                win_idx = GID_W'(cand);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        s_req_d    = s_req_q;
        s_we_d     = s_we_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        s_wstrb_d  = s_wstrb_q;
        m_rdata_d  = m_rdata_q;
        m_ready_d  = '0;
`ifdef ARB_TIMEOUT_EN
        wdog_d     = wdog_q;
        m_err_d    = m_err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d    = ST_BUSY;
                    s_req_d    = 1'b1;
                    s_we_d     = m_we[win_idx];
                    s_addr_d   = addr_arr[win_idx];
                    s_wdata_d  = wdata_arr[win_idx];
                    s_wstrb_d  = wstrb_arr[win_idx];
                    grant_id_d = win_idx;
`ifdef ARB_TIMEOUT_EN
                    wdog_d     = '0;
`endif
                end else begin
                    s_req_d = 1'b0;
                end
            end
            ST_BUSY: begin
                // m_ready is registered here so it is high for exactly the RESP cycle.
                if (s_ready) begin
                    state_d              = ST_RESP;
                    s_req_d              = 1'b0;
                    m_rdata_d            = s_rdata;
                    m_ready_d[grant_id_q] = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    m_err_d              = 1'b0;
                end else if (wdog_q == WD_W'(TIMEOUT_CYCLES)) begin
                    // Memory never answered: complete the transaction with an error.
                    state_d              = ST_RESP;
                    s_req_d              = 1'b0;
                    m_rdata_d            = TIMEOUT_DATA;
                    m_ready_d[grant_id_q] = 1'b1;
                    m_err_d              = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
`endif
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (grant_id_q == GID_W'(NUM_MASTERS - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = grant_id_q + 1'b1;
                end
`ifdef ARB_TIMEOUT_EN
                m_err_d = 1'b0;
`endif
            end
            default: begin
                state_d = ST_IDLE;
                s_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            grant_id_q <= '0;
            s_req_q    <= 1'b0;
            s_we_q     <= 1'b0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            s_wstrb_q  <= '0;
            m_rdata_q  <= '0;
            m_ready_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            s_req_q    <= s_req_d;
            s_we_q     <= s_we_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            s_wstrb_q  <= s_wstrb_d;
            m_rdata_q  <= m_rdata_d;
            m_ready_q  <= m_ready_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q  <= '0;
            m_err_q <= 1'b0;
        end else begin
            wdog_q  <= wdog_d;
            m_err_q <= m_err_d;
        end
    end

    assign m_err = m_err_q;
`else
    assign m_err = 1'b0;
`endif

    assign m_ready  = m_ready_q;
    assign m_rdata  = m_rdata_q;
    assign s_req    = s_req_q;
    assign s_we     = s_we_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign s_wstrb  = s_wstrb_q;
    assign grant_id = grant_id_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized traffic.
// Expected behaviour comes from a transaction-level model (round-robin pick, fixed response timing).
// Memory side is modelled with random or directed stall lengths.
module tb_mem_bus_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int GW = $clog2(N);
`ifdef ARB_TIMEOUT_EN
    localparam int TMO    = 8;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int TMO    = 0;
    localparam bit TMO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    m_req = '0;
    logic [N-1:0]    m_we = '0;
    logic [N*AW-1:0] m_addr = '0;
    logic [N*DW-1:0] m_wdata = '0;
    logic [N*SW-1:0] m_wstrb = '0;
    logic [N-1:0]    m_ready;
    logic [DW-1:0]   m_rdata;
    logic            m_err;
    logic            s_req, s_we;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic [SW-1:0]   s_wstrb;
    logic            s_ready = 1'b0;
    logic [DW-1:0]   s_rdata = '0;
    logic [GW-1:0]   grant_id;
    logic            busy;

    mem_bus_arbiter #(
        .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)
`ifdef ARB_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TMO)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_ready(m_ready), .m_rdata(m_rdata), .m_err(m_err),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state (transaction level).
    int            ptr_m = 0;
    bit            txn_open = 1'b0;   // a granted transaction awaits its response
    bit            resp_now = 1'b0;   // the previous cycle delivered a response
    int            win_m = 0;
    int            busy_cnt = 0;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic [SW-1:0] exp_wstrb;

    // Stimulus controls.
    int            wait_left = 0;
    int            dir_delay = 0;      // <0 selects random stall length
    bit            dir_rdata_en = 1'b0;
    logic [DW-1:0] dir_rdata = '0;
    bit            auto_mode = 1'b0;
    bit            hold_req = 1'b0;
    int            grant_log[$];

    function automatic int rr_pick(input logic [N-1:0] req, input int start);
        for (int k = 0; k < N; k++) begin
            int j;
            logic [N-1:0] bitmask;
            j = (start + k) % N;
            bitmask = N'(1) << j;
            if ((req & bitmask) != '0) return j;
        end
        return -1;
    endfunction

    task automatic set_master(input int i, input bit rq, input bit we, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [SW-1:0] s);
        m_req[i] = rq;
        m_we[i]  = we;
        m_addr[i*AW +: AW]  = a;
        m_wdata[i*DW +: DW] = d;
        m_wstrb[i*SW +: SW] = s;
    endtask

    // One clock: check DUT outputs against the model, then drive the next cycle's inputs.
    task automatic tick();
        logic [N-1:0] exp_rdy;
        int w;
        @(posedge clk);
        #1;
        exp_rdy = '0;
        if (rst) begin
            check_val("rst_sreq", s_req, 0);
            check_val("rst_mready", m_ready, 0);
            check_val("rst_busy", busy, 0);
            check_val("rst_gid", grant_id, 0);
            check_val("rst_rdata", m_rdata, 0);
            check_val("rst_saddr", s_addr, 0);
            txn_open = 1'b0; resp_now = 1'b0; ptr_m = 0; win_m = 0; busy_cnt = 0;
            rst = 1'b0;
            s_ready = 1'b0;
            return;
        end
        if (txn_open) begin
            if (s_ready || (TMO_EN && busy_cnt == TMO + 1)) begin
                exp_rdy = N'(1) << win_m;
                check_val("resp_mready", m_ready, exp_rdy);
                check_val("resp_rdata", m_rdata, s_ready ? s_rdata : DW'(32'hDEADBEEF));
                check_val("resp_err", m_err, s_ready ? 0 : 1);
                check_val("resp_sreq", s_req, 0);
                check_val("resp_busy", busy, 1);
                check_val("resp_gid", grant_id, win_m);
                grant_log.push_back(int'(grant_id));
                ptr_m = (win_m + 1) % N;
                txn_open = 1'b0;
                resp_now = 1'b1;
            end else begin
                check_val("hold_sreq", s_req, 1);
                check_val("hold_mready", m_ready, 0);
                check_val("hold_addr", s_addr, exp_addr);
                check_val("hold_we", s_we, exp_we);
                check_val("hold_wdata", s_wdata, exp_wdata);
                check_val("hold_wstrb", s_wstrb, exp_wstrb);
                check_val("hold_gid", grant_id, win_m);
                busy_cnt++;
            end
        end else if (resp_now) begin
            check_val("post_mready", m_ready, 0);
            check_val("post_sreq", s_req, 0);
            check_val("post_busy", busy, 0);
            check_val("post_gid", grant_id, win_m);
            resp_now = 1'b0;
        end else begin
            w = rr_pick(m_req, ptr_m);
            if (w >= 0) begin
                win_m     = w;
                exp_we    = m_we[w];
                exp_addr  = m_addr[w*AW +: AW];
                exp_wdata = m_wdata[w*DW +: DW];
                exp_wstrb = m_wstrb[w*SW +: SW];
                txn_open  = 1'b1;
                busy_cnt  = 1;
                wait_left = (dir_delay >= 0) ? dir_delay : $urandom_range(0, 4);
                check_val("grant_sreq", s_req, 1);
                check_val("grant_gid", grant_id, win_m);
                check_val("grant_addr", s_addr, exp_addr);
                check_val("grant_we", s_we, exp_we);
                check_val("grant_wdata", s_wdata, exp_wdata);
                check_val("grant_wstrb", s_wstrb, exp_wstrb);
                check_val("grant_busy", busy, 1);
            end else begin
                check_val("idle_sreq", s_req, 0);
                check_val("idle_busy", busy, 0);
                check_val("idle_mready", m_ready, 0);
                check_val("idle_gid", grant_id, win_m);
            end
        end
        // Memory side.
        if (txn_open) begin
            if (wait_left == 0) begin
                s_ready = 1'b1;
                s_rdata = dir_rdata_en ? dir_rdata : DW'($urandom);
            end else begin
                wait_left--;
                s_ready = 1'b0;
                s_rdata = DW'($urandom);
            end
        end else begin
            s_ready = auto_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
            s_rdata = DW'($urandom);
        end
        // Masters.
        for (int i = 0; i < N; i++) begin
            if (exp_rdy[i]) begin
                if (auto_mode && $urandom_range(0, 1) == 1)
                    set_master(i, 1'b1, 1'($urandom), $urandom, $urandom, SW'($urandom));
                else if (!hold_req)
                    m_req[i] = 1'b0;
            end else if (auto_mode && !m_req[i] && $urandom_range(0, 2) == 0) begin
                set_master(i, 1'b1, 1'($urandom), $urandom, $urandom, SW'($urandom));
            end else if (auto_mode && txn_open && i == win_m && $urandom_range(0, 1) == 1) begin
                m_addr[i*AW +: AW] = $urandom;
            end
        end
        if (auto_mode && $urandom_range(0, 299) == 0) rst = 1'b1;
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        tick();

        // Single read from master0.
        set_master(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        dir_delay = 0; dir_rdata_en = 1'b1; dir_rdata = 32'h12345678;
        tick();
        check_val("rd_saddr", s_addr, 32'h100);
        tick();
        check_val("rd_mready", m_ready, 3'b001);
        check_val("rd_rdata", m_rdata, 32'h12345678);
        tick();
        check_val("rd_busy_drop", busy, 0);
        dir_rdata_en = 1'b0;

        // Contention from a fresh pointer.
        rst = 1'b1;
        tick();
        hold_req = 1'b1;
        set_master(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        set_master(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        grant_log.delete();
        for (int t = 0; t < 40 && grant_log.size() < 4; t++) tick();
        hold_req = 1'b0;
        m_req = '0;
        check_val("cont_count", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            check_val("cont_g0", grant_log[0], 0);
            check_val("cont_g1", grant_log[1], 1);
            check_val("cont_g2", grant_log[2], 0);
            check_val("cont_g3", grant_log[3], 1);
        end
        tick(); tick();

        // Write from master1 with a short stall.
        set_master(1, 1'b1, 1'b1, 32'h200, 32'hCAFEF00D, 4'b0011);
        dir_delay = 3;
        tick();
        check_val("wr_swe", s_we, 1);
        check_val("wr_saddr", s_addr, 32'h200);
        check_val("wr_swdata", s_wdata, 32'hCAFEF00D);
        check_val("wr_swstrb", s_wstrb, 4'b0011);
        cnt = 0;
        while (m_ready == '0 && cnt < 20) begin tick(); cnt++; end
        check_val("wr_mready", m_ready, 3'b010);
        check_val("wr_latency", cnt, 4);
        tick(); tick();

        // Long stall while master0 keeps changing its address.
        set_master(0, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
        dir_delay = 9;
        tick();
        cnt = 1;
        for (int t = 0; t < 30 && s_req; t++) begin
            m_addr[0 +: AW] = $urandom;
            check_val("stall_saddr", s_addr, 32'h300);
            tick();
            if (s_req) cnt++;
        end
        check_val("stall_len", cnt, 10);
        tick(); tick();

        // Reset in the middle of BUSY.
        set_master(0, 1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
        dir_delay = 20;
        tick(); tick(); tick();
        rst = 1'b1;
        m_req = 3'b010;
        m_addr[AW +: AW] = 32'h500;
        dir_delay = 1;
        tick();
        tick();
        check_val("rstb_gid", grant_id, 1);
        check_val("rstb_saddr", s_addr, 32'h500);
        for (int t = 0; t < 10; t++) tick();

`ifdef ARB_TIMEOUT_EN
        // Memory never answers: watchdog completes with an error.
        set_master(2, 1'b1, 1'b0, 32'h600, 32'h0, 4'h0);
        dir_delay = 1000;
        tick();
        cnt = 0;
        while (m_ready == '0 && cnt < 40) begin tick(); cnt++; end
        check_val("tmo_latency", cnt, 9);
        check_val("tmo_err", m_err, 1);
        check_val("tmo_rdata", m_rdata, 32'hDEADBEEF);
        tick(); tick();
`endif

        // Randomized traffic.
        dir_delay = -1;
        auto_mode = 1'b1;
        for (int t = 0; t < 3000; t++) tick();
        auto_mode = 1'b0;
        m_req = '0;
        for (int t = 0; t < 20; t++) tick();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Round-robin arbiter sharing one memory port between NUM_MASTERS requesters, such as the per-core instruction and data ports of the multicore build. It latches the winning request, sequences a single outstanding transaction to the memory, and returns the response to the winner only. The block sits between the core memory interfaces and the shared imem/dmem model. Only one transaction is in flight at a time.

Parameters:
NUM_MASTERS, 2, number of requesters (2..8).
ADDR_W, 32, address width.
DATA_W, 32, data width; byte strobe width is DATA_W/8.
TIMEOUT_CYCLES, 64, watchdog limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous reset, active-high.
m_req  in  NUM_MASTERS  per-master request; held high until that master's m_ready.
m_we  in  NUM_MASTERS  per-master write enable.
m_addr  in  NUM_MASTERS*ADDR_W  flattened addresses; master i at [i*ADDR_W +: ADDR_W].
m_wdata  in  NUM_MASTERS*DATA_W  flattened write data.
m_wstrb  in  NUM_MASTERS*DATA_W/8  flattened byte strobes.
m_ready  out  NUM_MASTERS  one-cycle completion pulse to the granted master.
m_rdata  out  DATA_W  registered read data; valid only while some m_ready bit is high.
m_err  out  1  error flag qualified by m_ready; constant 0 without ARB_TIMEOUT_EN.
s_req  out  1  memory request, registered.
s_we  out  1  memory write enable.
s_addr  out  ADDR_W  memory address.
s_wdata  out  DATA_W  memory write data.
s_wstrb  out  DATA_W/8  memory byte strobes.
s_ready  in  1  memory completion, sampled only in BUSY.
s_rdata  in  DATA_W  memory read data, valid with s_ready.
grant_id  out  clog2(NUM_MASTERS) (min 1)  index of the current or last granted master.
busy  out  1  high when the state is not IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, priority pointer 0, watchdog 0. Reset has priority over every other event.
- Reset mid-transaction: the transaction is abandoned and no m_ready is issued. s_req is 0 from the reset edge onward.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If m_req is nonzero, pick the first asserted index searching from ptr upward, wrapping modulo NUM_MASTERS.
  - Latch that master's we, addr, wdata and wstrb into the s_* registers, set s_req=1 and grant_id=winner, then go to BUSY.
  - If m_req is zero, stay in IDLE with s_req=0.
- BUSY:
  - s_req and the s_* payload are held stable. m_req changes from other masters are ignored.
  - On s_ready=1: capture s_rdata into m_rdata, drop s_req to 0, go to RESP.
- RESP:
  - m_ready[grant_id]=1 for exactly this cycle; all other m_ready bits are 0.
  - Set ptr=(grant_id+1) mod NUM_MASTERS, then go to IDLE.
- Minimum latency: request sampled in IDLE at edge N; s_req is high in cycle N+1. If s_ready is high in cycle N+1, m_ready is high in cycle N+2. The next grant can issue s_req in cycle N+4.
- Masters: a master samples m_ready, then deasserts or changes m_req in the following cycle. A request that stays high after m_ready is treated as a new request.
- Write transactions: m_rdata is still updated from s_rdata, and its value is don't-care.
- Starvation-free: each requester is granted within NUM_MASTERS transactions.
- Simultaneous events: s_ready arriving in IDLE or RESP is ignored. A new m_req arriving during BUSY or RESP waits for IDLE.
- grant_id keeps its value in IDLE until the next grant.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counts BUSY cycles; it is cleared on entry to BUSY.
  - If it reaches TIMEOUT_CYCLES without s_ready: drop s_req, set m_rdata=0xDEADBEEF (truncated/zero-extended to DATA_W) and m_err=1, then enter RESP normally.
  - m_err is cleared when leaving RESP.
  - s_ready in the same cycle the watchdog expires wins: normal completion, m_err=0.
- Undefined: no counter exists, m_err is tied 0, and BUSY waits indefinitely.

Test Plan:
- Single read: master0 reads addr 0x100 and memory answers 0x12345678 one cycle after s_req -> s_addr=0x100, m_ready[0] pulses once, m_rdata=0x12345678, busy drops the next cycle.
- Contention: m_req=2'b11 held continuously, ptr=0 -> grant order 0,1,0,1 across 4 transactions; grant_id matches each m_ready.
- Write pass-through: master1 writes addr 0x200, wdata 0xCAFEF00D, wstrb 4'b0011 -> s_we=1 and the payload is exact on the s_* port for the whole BUSY; m_ready[1] follows s_ready.
- Stall hold: s_ready delayed 10 cycles while master0 changes m_addr -> s_addr stays at the latched value and s_req stays high 10 cycles.
- Reset mid-BUSY: rst=1 for 1 cycle during BUSY -> s_req=0, no m_ready, ptr=0, and the next m_req=2'b10 is granted to master1 normally.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: s_ready never asserted -> m_ready pulses 9 cycles after s_req rises, m_err=1, m_rdata=0xDEADBEEF.
